// File: rtl/filter_select_fade_pkg.sv
// ============================================================================
// Module   : filter_select_fade_pkg
// Purpose  : Shared constants for the frame-synchronous filter selector:
//            filter bank indices, FSM state encodings and a width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package filter_select_fade_pkg;

  // Filter bank slot assignments as wired by the filter bank.
  localparam logic [2:0] c_FILT_SEPIA     = 3'd0;
  localparam logic [2:0] c_FILT_INVERT    = 3'd1;
  localparam logic [2:0] c_FILT_EDGE      = 3'd2;
  localparam logic [2:0] c_FILT_CARTOON   = 3'd3;
  localparam logic [2:0] c_FILT_GRAYSCALE = 3'd4;

  // Selector FSM encoding.
  typedef logic [1:0] state_t;
  localparam state_t c_ST_IDLE  = 2'd0;
  localparam state_t c_ST_ARMED = 2'd1;
  localparam state_t c_ST_FADE  = 2'd2;

  // Alpha register width; an instant-switch build still needs one bit.
  function automatic int alpha_width(input int fade_log2);
    return (fade_log2 == 0) ? 1 : fade_log2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/filter_select_fade_if.sv
// ============================================================================
// Module   : filter_select_fade_if
// Purpose  : Bundles the selector's video/request inputs and status outputs.
// Ports    : i_filters_en, i_frame_start, i_sel_valid, i_sel_idx, i_rgb_in,
//            i_rgb_bank (inputs to the selector); o_rgb_out, o_filter,
//            o_busy, o_sel_err (outputs of the selector).
//            master = driver side, slave = selector side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface filter_select_fade_if #(
  parameter int PIX_W    = 8,
  parameter int NUM_FILT = 5,
  parameter int SEL_W    = 3
);

  logic                        i_filters_en;
  logic                        i_frame_start;
  logic                        i_sel_valid;
  logic [SEL_W-1:0]            i_sel_idx;
  logic [3*PIX_W-1:0]          i_rgb_in;
  logic [NUM_FILT*3*PIX_W-1:0] i_rgb_bank;
  logic [3*PIX_W-1:0]          o_rgb_out;
  logic [SEL_W-1:0]            o_filter;
  logic                        o_busy;
  logic                        o_sel_err;

  modport master (
    output i_filters_en, i_frame_start, i_sel_valid, i_sel_idx, i_rgb_in, i_rgb_bank,
    input  o_rgb_out, o_filter, o_busy, o_sel_err
  );

  modport slave (
    input  i_filters_en, i_frame_start, i_sel_valid, i_sel_idx, i_rgb_in, i_rgb_bank,
    output o_rgb_out, o_filter, o_busy, o_sel_err
  );

endinterface

`default_nettype wire

// File: rtl/filter_select_fade_pix_blend.sv
// ============================================================================
// Module   : filter_select_fade_pix_blend
// Purpose  : One colour channel of the crossfade:
//            o_pix = (old*(S-alpha) + new*alpha) >> FADE_LOG2, S = 2^FADE_LOG2
// Ports    : i_old   old-filter channel value
//            i_new   new-filter channel value
//            i_alpha fade position, 0..S-1 (0 = pure old)
//            o_pix   blended channel value (combinational)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module filter_select_fade_pix_blend
  import filter_select_fade_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int FADE_LOG2 = 2
) (
  input  wire logic [PIX_W-1:0]                      i_old,
  input  wire logic [PIX_W-1:0]                      i_new,
  input  wire logic [alpha_width(FADE_LOG2)-1:0]     i_alpha,
  output logic      [PIX_W-1:0]                      o_pix
);

  // The weights sum to S, so the sum never exceeds (2^PIX_W-1)*S; one spare
  // bit above PIX_W+FADE_LOG2 keeps the S-alpha term itself representable.
  localparam int                c_PROD_W = PIX_W + FADE_LOG2 + 1;
  localparam logic [c_PROD_W-1:0] c_SCALE = c_PROD_W'(1) << FADE_LOG2;

  logic [c_PROD_W-1:0] w_alpha;
  logic [c_PROD_W-1:0] w_sum;

  always_comb begin
    w_alpha = c_PROD_W'(i_alpha);
    w_sum   = c_PROD_W'(i_old) * (c_SCALE - w_alpha) + c_PROD_W'(i_new) * w_alpha;
    o_pix   = PIX_W'(w_sum >> FADE_LOG2);
  end

endmodule

`default_nettype wire

// File: rtl/filter_select_fade.sv
// ============================================================================
// Module   : filter_select_fade
// Purpose  : Selects one of NUM_FILT filter outputs for the display path.
//            Requests are held until a frame boundary so a frame is never
//            torn; optionally crossfades old->new over 2^FADE_LOG2 frames.
//            Pixel path is a fixed 2-cycle pipeline for every mode.
// Ports    : clk    pixel clock
//            rst_n  asynchronous reset, active low
//            bus    filter_select_fade_if.slave:
//                     i_filters_en  1 = filtered, 0 = bypass i_rgb_in
//                     i_frame_start one-cycle frame boundary pulse
//                     i_sel_valid / i_sel_idx  filter request strobe/index
//                     i_rgb_in, i_rgb_bank     raw pixel, filter outputs
//                     o_rgb_out  selected/blended pixel (registered)
//                     o_filter   committed filter index
//                     o_busy     request pending or fade running
//                     o_sel_err  one-cycle pulse on out-of-range request
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module filter_select_fade
  import filter_select_fade_pkg::*;
#(
  parameter int PIX_W      = 8,
  parameter int NUM_FILT   = 5,
  parameter int SEL_W      = 3,
  parameter int RESET_FILT = 4,
  parameter int FADE_LOG2  = 2
) (
  input  wire logic clk,
  input  wire logic rst_n,
  filter_select_fade_if.slave bus
);

  localparam int                   c_PIX3       = 3 * PIX_W;
  localparam int                   c_ALPHA_W    = alpha_width(FADE_LOG2);
  localparam logic [c_ALPHA_W-1:0] c_ALPHA_LAST = c_ALPHA_W'((2 ** FADE_LOG2) - 1);
  localparam logic [SEL_W-1:0]     c_RESET_IDX  = SEL_W'(RESET_FILT);

  // --------------------------------------------------------------------------
  // Selector state
  // --------------------------------------------------------------------------
  state_t                r_state;
  logic [SEL_W-1:0]      r_cur;     // committed (old) filter
  logic [SEL_W-1:0]      r_nxt;     // fade target
  logic [SEL_W-1:0]      r_pend;    // latest accepted request
  logic [c_ALPHA_W-1:0]  r_alpha;
  logic                  r_queued;  // request arrived while fading
  logic                  r_busy;
  logic                  r_sel_err;

  state_t                w_state_nxt;
  logic [SEL_W-1:0]      w_cur_nxt;
  logic [SEL_W-1:0]      w_nxt_nxt;
  logic [SEL_W-1:0]      w_pend_nxt;
  logic [c_ALPHA_W-1:0]  w_alpha_nxt;
  logic                  w_queued_nxt;
  logic                  w_busy_d;
  logic                  w_sel_err_d;

  logic                  w_legal;
  logic                  w_req;
  logic [SEL_W-1:0]      w_target;

  assign w_legal = (int'(bus.i_sel_idx) < NUM_FILT);
  assign w_req   = bus.i_sel_valid & w_legal;
  // A request arriving on the boundary cycle takes priority over the held one.
  assign w_target = w_req ? bus.i_sel_idx : r_pend;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_ST_IDLE;
      r_cur     <= c_RESET_IDX;
      r_nxt     <= c_RESET_IDX;
      r_pend    <= c_RESET_IDX;
      r_alpha   <= '0;
      r_queued  <= 1'b0;
      r_busy    <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur     <= w_cur_nxt;
      r_nxt     <= w_nxt_nxt;
      r_pend    <= w_pend_nxt;
      r_alpha   <= w_alpha_nxt;
      r_queued  <= w_queued_nxt;
      r_busy    <= w_busy_d;
      r_sel_err <= w_sel_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt  = r_state;
    w_cur_nxt    = r_cur;
    w_nxt_nxt    = r_nxt;
    w_pend_nxt   = r_pend;
    w_alpha_nxt  = r_alpha;
    w_queued_nxt = r_queued;

    case (r_state)
      c_ST_IDLE: begin
        if (w_req && (bus.i_sel_idx != r_cur)) begin
          w_pend_nxt  = bus.i_sel_idx;
          w_state_nxt = c_ST_ARMED;
        end
      end

      c_ST_ARMED: begin
        if (w_req && (bus.i_sel_idx == r_cur)) begin
          // Asking for the filter already on screen withdraws the request.
          w_pend_nxt  = r_cur;
          w_state_nxt = c_ST_IDLE;
        end else if (bus.i_frame_start) begin
          w_pend_nxt = w_target;
          w_nxt_nxt  = w_target;
          if (FADE_LOG2 == 0) begin
            w_cur_nxt   = w_target;
            w_state_nxt = c_ST_IDLE;
          end else begin
            w_alpha_nxt  = c_ALPHA_W'(1);
            w_queued_nxt = 1'b0;
            w_state_nxt  = c_ST_FADE;
          end
        end else if (w_req) begin
          w_pend_nxt = bus.i_sel_idx;
        end
      end

      c_ST_FADE: begin
        // A fade always runs to completion; requests only queue up behind it.
        if (w_req) begin
          w_pend_nxt   = bus.i_sel_idx;
          w_queued_nxt = 1'b1;
        end
        if (bus.i_frame_start) begin
          if (r_alpha != c_ALPHA_LAST) begin
            w_alpha_nxt = r_alpha + c_ALPHA_W'(1);
          end else begin
            w_cur_nxt    = r_nxt;
            w_alpha_nxt  = '0;
            w_queued_nxt = 1'b0;
            if ((r_queued || w_req) && (w_target != r_nxt)) begin
              w_state_nxt = c_ST_ARMED;
            end else begin
              w_state_nxt = c_ST_IDLE;
            end
          end
        end
      end

      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  // Output logic (registered alongside the state)
  always_comb begin
    w_busy_d    = (w_state_nxt != c_ST_IDLE);
    w_sel_err_d = bus.i_sel_valid & ~w_legal;
  end

  assign bus.o_filter  = r_cur;
  assign bus.o_busy    = r_busy;
  assign bus.o_sel_err = r_sel_err;

  // --------------------------------------------------------------------------
  // Bank slicing
  // --------------------------------------------------------------------------
  logic [c_PIX3-1:0] w_bank [NUM_FILT];

  for (genvar k = 0; k < NUM_FILT; k++) begin : g_bank
    assign w_bank[k] = bus.i_rgb_bank[k*c_PIX3 +: c_PIX3];
  end

  // --------------------------------------------------------------------------
  // Two-stage pixel pipeline
  // --------------------------------------------------------------------------
  logic [c_PIX3-1:0]    r_old_s1;
  logic [c_PIX3-1:0]    r_new_s1;
  logic [c_PIX3-1:0]    r_rgb_s1;
  logic [c_ALPHA_W-1:0] r_alpha_s1;
  logic [c_PIX3-1:0]    r_rgb_out;
  logic [c_PIX3-1:0]    w_blend;

  for (genvar c = 0; c < 3; c++) begin : g_chan
    filter_select_fade_pix_blend #(
      .PIX_W     (PIX_W),
      .FADE_LOG2 (FADE_LOG2)
    ) u_blend (
      .i_old   (r_old_s1[c*PIX_W +: PIX_W]),
      .i_new   (r_new_s1[c*PIX_W +: PIX_W]),
      .i_alpha (r_alpha_s1),
      .o_pix   (w_blend[c*PIX_W +: PIX_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_old_s1   <= '0;
      r_new_s1   <= '0;
      r_rgb_s1   <= '0;
      r_alpha_s1 <= '0;
      r_rgb_out  <= '0;
    end else begin
      r_old_s1   <= w_bank[r_cur];
      r_new_s1   <= w_bank[r_nxt];
      r_rgb_s1   <= bus.i_rgb_in;
      // alpha travels with the pixels so the blend weight matches its data.
      r_alpha_s1 <= r_alpha;
      r_rgb_out  <= bus.i_filters_en ? w_blend : r_rgb_s1;
    end
  end

  assign bus.o_rgb_out = r_rgb_out;

endmodule

`default_nettype wire

// File: tb/tb_filter_select_fade.sv
// ============================================================================
// Module   : tb_filter_select_fade
// Purpose  : Directed self-checking bench. u_dut0 is an instant-switch
//            build (FADE_LOG2=0), u_dut2 a 4-frame crossfade build.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_filter_select_fade;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  filter_select_fade_if #(.PIX_W(8), .NUM_FILT(5), .SEL_W(3)) if0 ();
  filter_select_fade_if #(.PIX_W(8), .NUM_FILT(5), .SEL_W(3)) if2 ();

  filter_select_fade #(
    .PIX_W(8), .NUM_FILT(5), .SEL_W(3), .RESET_FILT(4), .FADE_LOG2(0)
  ) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  filter_select_fade #(
    .PIX_W(8), .NUM_FILT(5), .SEL_W(3), .RESET_FILT(4), .FADE_LOG2(2)
  ) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Request strobe on the crossfade instance.
  task automatic req2(input logic [2:0] idx);
    if2.i_sel_valid = 1'b1;
    if2.i_sel_idx   = idx;
    tick();
    if2.i_sel_valid = 1'b0;
  endtask

  task automatic req0(input logic [2:0] idx);
    if0.i_sel_valid = 1'b1;
    if0.i_sel_idx   = idx;
    tick();
    if0.i_sel_valid = 1'b0;
  endtask

  // Boundary pulse on the crossfade instance, then enough cycles for the
  // 2-stage pipeline to show the new blend.
  task automatic frame2();
    if2.i_frame_start = 1'b1;
    tick();
    if2.i_frame_start = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;

    if0.i_filters_en = 1'b1;  if2.i_filters_en = 1'b1;
    if0.i_frame_start = 1'b0; if2.i_frame_start = 1'b0;
    if0.i_sel_valid = 1'b0;   if2.i_sel_valid = 1'b0;
    if0.i_sel_idx = 3'd0;     if2.i_sel_idx = 3'd0;
    if0.i_rgb_in = 24'h123456; if2.i_rgb_in = 24'h123456;
    // bank slots: 0=102030 1=FFFFFF 2=405060 3=0A0B0C 4=808080
    if0.i_rgb_bank = {24'h808080, 24'h0A0B0C, 24'h405060, 24'hFFFFFF, 24'h102030};
    if2.i_rgb_bank = {24'h808080, 24'h0A0B0C, 24'h405060, 24'hFFFFFF, 24'h102030};

    // ---- 1: reset state and first pixel ----
    tick(); tick(); tick();
    check("rst_rgb_out", 32'(if2.o_rgb_out), 32'h0);
    check("rst_filter",  32'(if2.o_filter),  32'd4);
    check("rst_busy",    32'(if2.o_busy),    32'd0);
    check("rst_sel_err", 32'(if2.o_sel_err), 32'd0);
    rst_n = 1'b1;
    tick(); tick();
    check("t1_rgb_out", 32'(if2.o_rgb_out), 32'h808080);
    check("t1_filter",  32'(if2.o_filter),  32'd4);
    check("t1_busy",    32'(if2.o_busy),    32'd0);

    // ---- 2: instant switch build ----
    req0(3'd1);
    check("t2_hold_filter", 32'(if0.o_filter), 32'd4);
    check("t2_hold_busy",   32'(if0.o_busy),   32'd1);
    tick(); tick();
    check("t2_wait_filter", 32'(if0.o_filter), 32'd4);
    if0.i_frame_start = 1'b1;
    tick();
    if0.i_frame_start = 1'b0;
    check("t2_commit_filter", 32'(if0.o_filter), 32'd1);
    check("t2_commit_busy",   32'(if0.o_busy),   32'd0);
    tick(); tick();
    check("t2_rgb_out", 32'(if0.o_rgb_out), 32'hFFFFFF);
    // same as current while idle: ignored
    req0(3'd1);
    check("t2_same_idle_busy", 32'(if0.o_busy), 32'd0);
    // armed then cancelled by asking for the current filter
    req0(3'd3);
    check("t2_armed_busy", 32'(if0.o_busy), 32'd1);
    req0(3'd1);
    check("t2_cancel_busy", 32'(if0.o_busy), 32'd0);
    if0.i_frame_start = 1'b1;
    tick();
    if0.i_frame_start = 1'b0;
    check("t2_cancel_filter", 32'(if0.o_filter), 32'd1);
    // request arriving on the boundary cycle wins over the held one
    req0(3'd2);
    if0.i_sel_valid = 1'b1;
    if0.i_sel_idx = 3'd3;
    if0.i_frame_start = 1'b1;
    tick();
    if0.i_sel_valid = 1'b0;
    if0.i_frame_start = 1'b0;
    check("t2_bypass_pend_filter", 32'(if0.o_filter), 32'd3);
    check("t2_bypass_pend_busy",   32'(if0.o_busy),   32'd0);

    // ---- 3: 4-frame crossfade 000000 -> FFFFFF ----
    if2.i_rgb_bank[4*24 +: 24] = 24'h000000;
    tick(); tick();
    check("t3_start_rgb", 32'(if2.o_rgb_out), 32'h000000);
    req2(3'd1);
    check("t3_armed_busy", 32'(if2.o_busy), 32'd1);
    frame2();
    check("t3_a1_rgb",    32'(if2.o_rgb_out), 32'h3F3F3F);
    check("t3_a1_filter", 32'(if2.o_filter),  32'd4);
    frame2();
    check("t3_a2_rgb", 32'(if2.o_rgb_out), 32'h7F7F7F);
    frame2();
    check("t3_a3_rgb",    32'(if2.o_rgb_out), 32'hBFBFBF);
    check("t3_a3_filter", 32'(if2.o_filter),  32'd4);
    check("t3_a3_busy",   32'(if2.o_busy),    32'd1);
    frame2();
    check("t3_done_rgb",    32'(if2.o_rgb_out), 32'hFFFFFF);
    check("t3_done_filter", 32'(if2.o_filter),  32'd1);
    check("t3_done_busy",   32'(if2.o_busy),    32'd0);

    // ---- 4: last request wins, illegal index rejected ----
    req2(3'd3);
    req2(3'd2);
    check("t4_armed_busy", 32'(if2.o_busy), 32'd1);
    req2(3'd7);
    check("t4_err_pulse", 32'(if2.o_sel_err), 32'd1);
    tick();
    check("t4_err_clear",  32'(if2.o_sel_err), 32'd0);
    check("t4_err_filter", 32'(if2.o_filter),  32'd1);
    check("t4_err_busy",   32'(if2.o_busy),    32'd1);
    frame2();
    // FFFFFF -> 405060 at alpha=1
    check("t4_a1_rgb", 32'(if2.o_rgb_out), 32'hCFD3D7);
    frame2(); frame2(); frame2();
    check("t4_done_filter", 32'(if2.o_filter),  32'd2);
    check("t4_done_rgb",    32'(if2.o_rgb_out), 32'h405060);
    req2(3'd7);
    check("t4_idle_err",  32'(if2.o_sel_err), 32'd1);
    check("t4_idle_busy", 32'(if2.o_busy),    32'd0);

    // ---- 5: request queued during a fade ----
    req2(3'd0);
    frame2();
    req2(3'd3);
    frame2(); frame2(); frame2();
    check("t5_first_filter", 32'(if2.o_filter),  32'd0);
    check("t5_armed_busy",   32'(if2.o_busy),    32'd1);
    check("t5_first_rgb",    32'(if2.o_rgb_out), 32'h102030);
    frame2();
    // 102030 -> 0A0B0C at alpha=1
    check("t5_a1_rgb",    32'(if2.o_rgb_out), 32'h0E1A27);
    check("t5_a1_filter", 32'(if2.o_filter),  32'd0);
    frame2(); frame2(); frame2();
    check("t5_done_filter", 32'(if2.o_filter),  32'd3);
    check("t5_done_busy",   32'(if2.o_busy),    32'd0);
    check("t5_done_rgb",    32'(if2.o_rgb_out), 32'h0A0B0C);

    // ---- 6: reset mid-fade, then bypass path ----
    req2(3'd1);
    frame2();
    // 0A0B0C -> FFFFFF at alpha=1
    check("t6_a1_rgb", 32'(if2.o_rgb_out), 32'h474848);
    rst_n = 1'b0;
    #1;
    check("t6_rst_rgb",    32'(if2.o_rgb_out), 32'h0);
    check("t6_rst_filter", 32'(if2.o_filter),  32'd4);
    check("t6_rst_busy",   32'(if2.o_busy),    32'd0);
    tick();
    rst_n = 1'b1;
    if2.i_filters_en = 1'b0;
    if2.i_rgb_in = 24'hA1B2C3;
    tick();
    if2.i_rgb_in = 24'h0F1E2D;
    tick();
    check("t6_byp0", 32'(if2.o_rgb_out), 32'hA1B2C3);
    if2.i_rgb_in = 24'h5A5A5A;
    tick();
    check("t6_byp1", 32'(if2.o_rgb_out), 32'h0F1E2D);
    tick();
    check("t6_byp2", 32'(if2.o_rgb_out), 32'h5A5A5A);
    req2(3'd0);
    check("t6_fsm_runs_busy", 32'(if2.o_busy), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
